// File: rtl/btn_pkg.sv
// btn_pkg: FSM state encoding and default timing parameters for button_event_ctrl
package btn_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;
    localparam int LAST_CYCLES_DEF   = 2_000_000;
    localparam int LONG_CYCLES_DEF   = 100_000_000;
    localparam int DCLICK_CYCLES_DEF = 30_000_000;
endpackage

// File: rtl/button_event_ctrl_debounce.sv
// debounce: two-flop synchroniser plus stability counter; s follows the input once it has differed for LAST_CYCLES cycles
module debounce import btn_pkg::*; #(
    parameter int LAST_CYCLES = LAST_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    output logic s
);
    localparam int CW = $clog2(LAST_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            s    <= 1'b0;
        end else begin
            sync <= {sync[0], noisy};
            if (sync[1] == s) begin
                cnt <= '0;
            end else if (cnt == CW'(LAST_CYCLES - 1)) begin
                s   <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: classifies debounced button gestures into single, double and long click pulses
module button_event_ctrl import btn_pkg::*; #(
    parameter int LAST_CYCLES   = LAST_CYCLES_DEF,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int DCLICK_CYCLES = DCLICK_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic noisy_in,
    output logic single_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic held,
    output logic busy
);
    localparam int CMAX = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] LONG_END = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] DCLK_END = CW'(DCLICK_CYCLES - 1);
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [2:0]    pulse_nx;
    logic          s;
    debounce #(.LAST_CYCLES(LAST_CYCLES)) u_debounce (
        .clk   (clk),
        .rst_n (~rst),
        .noisy (noisy_in),
        .s     (s)
    );
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            {single_pulse, double_pulse, long_pulse} <= '0;
            held  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            {single_pulse, double_pulse, long_pulse} <= pulse_nx;
            held  <= s;
            busy  <= state_nx != IDLE;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            IDLE:      state_nx = s ? PRESS1 : IDLE;
            PRESS1: begin
                state_nx = !s ? WAIT2 : (cnt == LONG_END) ? LONG_HOLD : PRESS1;
                cnt_nx   = s ? cnt_inc : '0;
            end
            WAIT2: begin
                // a rise on the final gap cycle still counts as a double click
                state_nx = s ? PRESS2 : (cnt == DCLK_END) ? IDLE : WAIT2;
                cnt_nx   = (s || cnt == DCLK_END) ? '0 : cnt_inc;
            end
            PRESS2:    state_nx = s ? PRESS2 : IDLE;
            LONG_HOLD: begin
                state_nx = s ? LONG_HOLD : IDLE;
                cnt_nx   = s ? cnt : '0;
            end
            default:   state_nx = IDLE;
        endcase
    end
    always_comb begin
        pulse_nx = {state == WAIT2 && !s && cnt == DCLK_END,
                    state == WAIT2 && s,
                    state == PRESS1 && s && cnt == LONG_END};
    end
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed gesture scenarios with hand-computed pulse timing
module tb_button_event_ctrl;
    logic clk = 1'b0;
    logic rst, noisy_in;
    logic single_pulse, double_pulse, long_pulse, held, busy;
    int cyc = 0, n_chk = 0, n_fail = 0;
    int n_single = 0, n_double = 0, n_long = 0, n_busy = 0, n_overlap = 0;
    int t_single = -1, t_double = -1, t_long = -1;
    int c, bs, bd, bl, bb;

    button_event_ctrl #(.LAST_CYCLES(4), .LONG_CYCLES(20), .DCLICK_CYCLES(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .noisy_in     (noisy_in),
        .single_pulse (single_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .held         (held),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (single_pulse) begin n_single++; t_single = cyc; end
        if (double_pulse) begin n_double++; t_double = cyc; end
        if (long_pulse)   begin n_long++;   t_long   = cyc; end
        if (busy) n_busy++;
        if (int'(single_pulse) + int'(double_pulse) + int'(long_pulse) > 1) n_overlap++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < c + t) tick(1);
    endtask

    task automatic start;
        tick(1);
        c  = cyc;
        bs = n_single; bd = n_double; bl = n_long; bb = n_busy;
    endtask

    initial begin
        rst = 1'b1;
        noisy_in = 1'b0;
        #1;
        chk("reset_outputs", int'({single_pulse, double_pulse, long_pulse, held, busy}), 0);
        tick(3);
        rst = 1'b0;
        tick(5);

        // bouncing press, short hold, release -> single click
        start();
        noisy_in = 1'b1; wait_to(1);
        noisy_in = 1'b0; wait_to(2);
        noisy_in = 1'b1; wait_to(11);
        chk("s1_held", int'(held), 1);
        noisy_in = 1'b0; wait_to(40);
        chk("s1_single_n", n_single - bs, 1);
        chk("s1_single_t", t_single - c, 28);
        chk("s1_double_n", n_double - bd, 0);
        chk("s1_long_n", n_long - bl, 0);
        chk("s1_busy", int'(busy), 0);

        // two short presses with a 5-cycle gap -> double click
        start();
        noisy_in = 1'b1; wait_to(8);
        noisy_in = 1'b0; wait_to(13);
        noisy_in = 1'b1; wait_to(21);
        chk("s2_busy_press2", int'(busy), 1);
        noisy_in = 1'b0; wait_to(45);
        chk("s2_double_n", n_double - bd, 1);
        chk("s2_double_t", t_double - c, 20);
        chk("s2_single_n", n_single - bs, 0);
        chk("s2_long_n", n_long - bl, 0);
        chk("s2_busy_end", int'(busy), 0);

        // 40-cycle hold -> one long pulse, silent release
        start();
        noisy_in = 1'b1; wait_to(40);
        chk("s3_held", int'(held), 1);
        chk("s3_busy_hold", int'(busy), 1);
        noisy_in = 1'b0; wait_to(70);
        chk("s3_long_n", n_long - bl, 1);
        chk("s3_long_t", t_long - c, 27);
        chk("s3_single_n", n_single - bs, 0);
        chk("s3_double_n", n_double - bd, 0);
        chk("s3_busy_end", int'(busy), 0);
        chk("s3_held_end", int'(held), 0);

        // second rise lands on the last gap cycle -> double wins
        start();
        noisy_in = 1'b1; wait_to(5);
        noisy_in = 1'b0; wait_to(15);
        noisy_in = 1'b1; wait_to(20);
        noisy_in = 1'b0; wait_to(45);
        chk("s4_double_n", n_double - bd, 1);
        chk("s4_double_t", t_double - c, 22);
        chk("s4_single_n", n_single - bs, 0);

        // one cycle later the gap has expired -> two singles
        start();
        noisy_in = 1'b1; wait_to(5);
        noisy_in = 1'b0; wait_to(16);
        noisy_in = 1'b1; wait_to(21);
        noisy_in = 1'b0; wait_to(60);
        chk("s4b_single_n", n_single - bs, 2);
        chk("s4b_single_t", t_single - c, 38);
        chk("s4b_double_n", n_double - bd, 0);

        // reset during WAIT2 discards the click
        start();
        noisy_in = 1'b1; wait_to(5);
        noisy_in = 1'b0; wait_to(15);
        chk("s5_busy_wait2", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("s5_outputs_in_rst", int'({single_pulse, double_pulse, long_pulse, held, busy}), 0);
        tick(2);
        rst = 1'b0;
        wait_to(45);
        chk("s5_single_n", n_single - bs, 0);
        chk("s5_double_n", n_double - bd, 0);
        chk("s5_busy", int'(busy), 0);

        // reset during a press still held -> fresh PRESS1 after reset
        start();
        noisy_in = 1'b1; wait_to(10);
        rst = 1'b1; wait_to(12);
        rst = 1'b0; wait_to(45);
        noisy_in = 1'b0; wait_to(75);
        chk("s6_long_n", n_long - bl, 1);
        chk("s6_long_t", t_long - c, 39);
        chk("s6_single_n", n_single - bs, 0);
        chk("s6_double_n", n_double - bd, 0);

        // glitches of 3 cycles never pass the debouncer
        start();
        noisy_in = 1'b1; wait_to(3);
        noisy_in = 1'b0; wait_to(4);
        noisy_in = 1'b1; wait_to(7);
        noisy_in = 1'b0; wait_to(8);
        noisy_in = 1'b1; wait_to(11);
        noisy_in = 1'b0; wait_to(30);
        chk("s7_pulses", (n_single - bs) + (n_double - bd) + (n_long - bl), 0);
        chk("s7_busy_cycles", n_busy - bb, 0);
        chk("s7_held", int'(held), 0);

        chk("pulse_overlap", n_overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
